// File: rtl/lap_stopwatch.sv
// lap_stopwatch: MM:SS up/down timer with built-in prescaler, run/pause
// control, lap-freeze display and down-count completion flag.
// Outputs four BCD digits plus status flags.
module lap_stopwatch #(
  parameter int unsigned CLK_HZ  = 50000000,
  parameter int unsigned TICK_HZ = 1,
  parameter int unsigned MAX_MIN = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  input  logic       mode,
  input  logic [3:0] preset_mt,
  input  logic [3:0] preset_mu,
  input  logic [2:0] preset_st,
  input  logic [3:0] preset_su,
  output logic [3:0] disp_mt,
  output logic [3:0] disp_mu,
  output logic [2:0] disp_st,
  output logic [3:0] disp_su,
  output logic       running,
  output logic       lapped,
  output logic       done,
  output logic       wrap
);

  localparam int unsigned DIV      = ((CLK_HZ / TICK_HZ) > 1) ? (CLK_HZ / TICK_HZ) : 1;
  localparam int unsigned PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [7:0]  MAX_M8   = 8'(MAX_MIN);
  localparam logic [3:0]  MAX_MT   = 4'(MAX_MIN / 10);
  localparam logic [3:0]  MAX_MU   = 4'(MAX_MIN % 10);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_e;

  typedef struct packed {
    logic [3:0] mt;
    logic [3:0] mu;
    logic [2:0] st;
    logic [3:0] su;
  } bcd_t;

  state_e        state_q, state_d;
  bcd_t          count_q, count_d;
  bcd_t          lap_cnt_q, lap_cnt_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          mode_q, mode_d;
  logic          lapped_q, lapped_d;
  logic          wrap_q, wrap_d;
  logic          ss_prev_q, lap_prev_q;

  logic          ss_press, lap_press, tick;
  logic          at_max, count_zero;
  bcd_t          ld_cnt, inc_cnt, dec_cnt;
  logic [3:0]    pmu_c;

  function automatic logic [7:0] minutes(input logic [3:0] t, input logic [3:0] u);
    return 8'(t) * 8'd10 + 8'(u);
  endfunction

  function automatic bcd_t bcd_inc(input bcd_t c);
    bcd_t r;
    r = c;
    if (c.su != 4'd9) r.su = c.su + 4'd1;
    else begin
      r.su = '0;
      if (c.st != 3'd5) r.st = c.st + 3'd1;
      else begin
        r.st = '0;
        if (c.mu != 4'd9) r.mu = c.mu + 4'd1;
        else begin
          r.mu = '0;
          r.mt = c.mt + 4'd1;
        end
      end
    end
    return r;
  endfunction

  function automatic bcd_t bcd_dec(input bcd_t c);
    bcd_t r;
    r = c;
    if (c.su != 4'd0) r.su = c.su - 4'd1;
    else begin
      r.su = 4'd9;
      if (c.st != 3'd0) r.st = c.st - 3'd1;
      else begin
        r.st = 3'd5;
        if (c.mu != 4'd0) r.mu = c.mu - 4'd1;
        else begin
          r.mu = 4'd9;
          r.mt = c.mt - 4'd1;
        end
      end
    end
    return r;
  endfunction

  assign ss_press   = start_stop & ~ss_prev_q;
  assign lap_press  = lap & ~lap_prev_q;
  assign tick       = (state_q == S_RUN) && (presc_q == PRE_LAST);
  assign at_max     = (minutes(count_q.mt, count_q.mu) == MAX_M8) &&
                      (count_q.st == 3'd5) && (count_q.su == 4'd9);
  assign count_zero = (count_q == '0);
  assign inc_cnt    = bcd_inc(count_q);
  assign dec_cnt    = bcd_dec(count_q);

  // Preset clamp: minute units saturate first, then the whole minute value.
  always_comb begin
    pmu_c     = (preset_mu > 4'd9) ? 4'd9 : preset_mu;
    ld_cnt.st = (preset_st > 3'd5) ? 3'd5 : preset_st;
    ld_cnt.su = (preset_su > 4'd9) ? 4'd9 : preset_su;
    if (minutes(preset_mt, pmu_c) > MAX_M8) begin
      ld_cnt.mt = MAX_MT;
      ld_cnt.mu = MAX_MU;
    end else begin
      ld_cnt.mt = preset_mt;
      ld_cnt.mu = pmu_c;
    end
  end

  // Next-state and datapath: clear/IDLE load, run/pause, lap toggle, tick counting.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    lap_cnt_d = lap_cnt_q;
    presc_d   = presc_q;
    mode_d    = mode_q;
    lapped_d  = lapped_q;
    wrap_d    = 1'b0;
    if (clear || (state_q == S_IDLE)) begin
      mode_d   = mode;
      count_d  = mode ? ld_cnt : '0;
      presc_d  = '0;
      lapped_d = 1'b0;
      state_d  = S_IDLE;
      if (!clear && ss_press)
        state_d = (mode_q && count_zero) ? S_DONE : S_RUN;
    end else begin
      unique case (state_q)
        S_RUN, S_PAUSE: begin
          if (state_q == S_RUN)
            presc_d = tick ? '0 : presc_q + PW'(1);
          if (ss_press)
            state_d = (state_q == S_RUN) ? S_PAUSE : S_RUN;
          if (lap_press) begin
            lapped_d = ~lapped_q;
            if (!lapped_q) lap_cnt_d = count_q;
          end
          // A tick still lands on a pause edge; reaching zero overrides the pause
          // and the lap toggle so the final 00:00 is shown.
          if (tick) begin
            if (!mode_q) begin
              if (at_max) begin
                count_d = '0;
                wrap_d  = 1'b1;
              end else begin
                count_d = inc_cnt;
              end
            end else begin
              count_d = dec_cnt;
              if (dec_cnt == '0) begin
                state_d  = S_DONE;
                lapped_d = 1'b0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers and button edge-detect copies.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q    <= '0;
      lap_cnt_q  <= '0;
      presc_q    <= '0;
      mode_q     <= 1'b0;
      lapped_q   <= 1'b0;
      wrap_q     <= 1'b0;
      ss_prev_q  <= 1'b0;
      lap_prev_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      lap_cnt_q  <= lap_cnt_d;
      presc_q    <= presc_d;
      mode_q     <= mode_d;
      lapped_q   <= lapped_d;
      wrap_q     <= wrap_d;
      ss_prev_q  <= start_stop;
      lap_prev_q <= lap;
    end
  end

  assign disp_mt = lapped_q ? lap_cnt_q.mt : count_q.mt;
  assign disp_mu = lapped_q ? lap_cnt_q.mu : count_q.mu;
  assign disp_st = lapped_q ? lap_cnt_q.st : count_q.st;
  assign disp_su = lapped_q ? lap_cnt_q.su : count_q.su;
  assign running = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign lapped  = lapped_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Bench for lap_stopwatch: two instances (MAX_MIN 59 and 1, 4 clocks per
// second) share inputs and are compared with a seconds-based reference model.
module tb_lap_stopwatch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start_stop, lap, clear, mode;
  logic [3:0] preset_mt, preset_mu, preset_su;
  logic [2:0] preset_st;

  logic [3:0] d_mt [2];
  logic [3:0] d_mu [2];
  logic [2:0] d_st [2];
  logic [3:0] d_su [2];
  logic       d_run [2];
  logic       d_lap [2];
  logic       d_done [2];
  logic       d_wrap [2];

  int n_checks = 0;
  int n_fail   = 0;

  lap_stopwatch #(.CLK_HZ(4), .TICK_HZ(1), .MAX_MIN(59)) dut_a (
    .clk(clk), .reset(reset), .start_stop(start_stop), .lap(lap), .clear(clear), .mode(mode),
    .preset_mt(preset_mt), .preset_mu(preset_mu), .preset_st(preset_st), .preset_su(preset_su),
    .disp_mt(d_mt[0]), .disp_mu(d_mu[0]), .disp_st(d_st[0]), .disp_su(d_su[0]),
    .running(d_run[0]), .lapped(d_lap[0]), .done(d_done[0]), .wrap(d_wrap[0]));

  lap_stopwatch #(.CLK_HZ(4), .TICK_HZ(1), .MAX_MIN(1)) dut_b (
    .clk(clk), .reset(reset), .start_stop(start_stop), .lap(lap), .clear(clear), .mode(mode),
    .preset_mt(preset_mt), .preset_mu(preset_mu), .preset_st(preset_st), .preset_su(preset_su),
    .disp_mt(d_mt[1]), .disp_mu(d_mu[1]), .disp_st(d_st[1]), .disp_su(d_su[1]),
    .running(d_run[1]), .lapped(d_lap[1]), .done(d_done[1]), .wrap(d_wrap[1]));

  // ---------------- reference model (time kept as total seconds) ----------
  localparam int CPS = 4;  // clocks per second
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  int maxm [2] = '{59, 1};
  int m_state [2];
  int m_secs [2];
  int m_lapsecs [2];
  int m_phase [2];
  bit m_lapped [2];
  bit m_wrap [2];
  bit m_mode [2];
  bit m_prev_ss, m_prev_lap;

  function automatic int preset_secs(int k);
    int mu, mins, st, su;
    mu   = (preset_mu > 9) ? 9 : int'(preset_mu);
    mins = int'(preset_mt) * 10 + mu;
    if (mins > maxm[k]) mins = maxm[k];
    st = (preset_st > 5) ? 5 : int'(preset_st);
    su = (preset_su > 9) ? 9 : int'(preset_su);
    return mins * 60 + st * 10 + su;
  endfunction

  function automatic void model_step(int k, bit pss, bit plap);
    int nxt;
    bit ticked;
    m_wrap[k] = 1'b0;
    if (clear || m_state[k] == M_IDLE) begin
      nxt = M_IDLE;
      if (!clear && pss) nxt = (m_mode[k] && m_secs[k] == 0) ? M_DONE : M_RUN;
      m_mode[k]   = mode;
      m_secs[k]   = mode ? preset_secs(k) : 0;
      m_phase[k]  = 0;
      m_lapped[k] = 1'b0;
      m_state[k]  = nxt;
    end else if (m_state[k] == M_RUN || m_state[k] == M_PAUSE) begin
      ticked = (m_state[k] == M_RUN) && (m_phase[k] == CPS - 1);
      if (m_state[k] == M_RUN) m_phase[k] = (m_phase[k] + 1) % CPS;
      if (plap) begin
        if (!m_lapped[k]) m_lapsecs[k] = m_secs[k];
        m_lapped[k] = !m_lapped[k];
      end
      if (pss) m_state[k] = (m_state[k] == M_RUN) ? M_PAUSE : M_RUN;
      if (ticked) begin
        if (!m_mode[k]) begin
          m_secs[k] = (m_secs[k] + 1) % ((maxm[k] + 1) * 60);
          m_wrap[k] = (m_secs[k] == 0);
        end else begin
          m_secs[k] = m_secs[k] - 1;
          if (m_secs[k] == 0) begin
            m_state[k]  = M_DONE;
            m_lapped[k] = 1'b0;
          end
        end
      end
    end
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        m_state[k] = M_IDLE; m_secs[k] = 0; m_lapsecs[k] = 0; m_phase[k] = 0;
        m_lapped[k] = 1'b0; m_wrap[k] = 1'b0; m_mode[k] = 1'b0;
      end
      m_prev_ss  = 1'b0;
      m_prev_lap = 1'b0;
    end else begin
      for (int k = 0; k < 2; k++)
        model_step(k, start_stop && !m_prev_ss, lap && !m_prev_lap);
      m_prev_ss  = start_stop;
      m_prev_lap = lap;
    end
  end

  function automatic logic [14:0] to_disp(int s);
    int mins, secs;
    mins = s / 60;
    secs = s % 60;
    return {4'(mins / 10), 4'(mins % 10), 3'(secs / 10), 4'(secs % 10)};
  endfunction

  // Packed view: {display, running, lapped, done, wrap}
  function automatic logic [18:0] obs_vec(int k);
    return {d_mt[k], d_mu[k], d_st[k], d_su[k], d_run[k], d_lap[k], d_done[k], d_wrap[k]};
  endfunction

  function automatic logic [18:0] exp_vec(int k);
    return {to_disp(m_lapped[k] ? m_lapsecs[k] : m_secs[k]), m_state[k] == M_RUN,
            m_lapped[k], m_state[k] == M_DONE, m_wrap[k]};
  endfunction

  // ---------------- stimulus helpers --------------------------------------
  task automatic waitn(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_ss();
    @(negedge clk) start_stop = 1'b1;
    @(negedge clk) start_stop = 1'b0;
  endtask

  task automatic press_lap();
    @(negedge clk) lap = 1'b1;
    @(negedge clk) lap = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk) clear = 1'b1;
    @(negedge clk) clear = 1'b0;
  endtask

  // ---------------- tests --------------------------------------------------
  task automatic test_reset();
    reset = 1'b0; start_stop = 1'b0; lap = 1'b0; clear = 1'b0; mode = 1'b0;
    preset_mt = '0; preset_mu = '0; preset_st = '0; preset_su = '0;
    waitn(3);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs_vec(k) !== 19'd0) begin
        n_fail++; $display("FAIL reset_outputs dut%0d: got %h expected %h", k, obs_vec(k), 19'd0);
      end
    end
    @(negedge clk) reset = 1'b1;
    waitn(2);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs_vec(k) !== exp_vec(k)) begin
        n_fail++; $display("FAIL reset_release dut%0d: got %h expected %h", k, obs_vec(k), exp_vec(k));
      end
    end
  endtask

  task automatic test_run_pause();
    logic [18:0] e;
    mode = 1'b0;
    pulse_clear();
    press_ss();
    waitn(40);
    e = {to_disp(10), 4'b1000};
    n_checks++;
    if (obs_vec(0) !== e) begin n_fail++; $display("FAIL run_40clk: got %h expected %h", obs_vec(0), e); end
    press_ss();
    e = {to_disp(10), 4'b0000};
    n_checks++;
    if (obs_vec(0) !== e) begin n_fail++; $display("FAIL pause: got %h expected %h", obs_vec(0), e); end
    waitn(20);
    n_checks++;
    if (obs_vec(0) !== e) begin n_fail++; $display("FAIL pause_hold: got %h expected %h", obs_vec(0), e); end
    press_ss();
    waitn(4);
    e = {to_disp(11), 4'b1000};
    n_checks++;
    if (obs_vec(0) !== e) begin n_fail++; $display("FAIL resume_partial: got %h expected %h", obs_vec(0), e); end
    n_checks++;
    if (obs_vec(1) !== exp_vec(1)) begin
      n_fail++; $display("FAIL run_pause_model dut1: got %h expected %h", obs_vec(1), exp_vec(1));
    end
  endtask

  task automatic test_wrap();
    logic [18:0] e;
    int wraps;
    mode = 1'b0;
    pulse_clear();
    press_ss();
    waitn(476);
    e = {to_disp(119), 4'b1000};
    n_checks++;
    if (obs_vec(1) !== e) begin n_fail++; $display("FAIL wrap_pre: got %h expected %h", obs_vec(1), e); end
    waitn(3);
    waitn(1);
    e = {to_disp(0), 4'b1001};
    n_checks++;
    if (obs_vec(1) !== e) begin n_fail++; $display("FAIL wrap_edge: got %h expected %h", obs_vec(1), e); end
    waitn(1);
    e = {to_disp(0), 4'b1000};
    n_checks++;
    if (obs_vec(1) !== e) begin n_fail++; $display("FAIL wrap_one_cycle: got %h expected %h", obs_vec(1), e); end
    n_checks++;
    if (obs_vec(0) !== exp_vec(0)) begin
      n_fail++; $display("FAIL no_wrap_dut0: got %h expected %h", obs_vec(0), exp_vec(0));
    end
    wraps = 0;
    for (int i = 0; i < 20; i++) begin
      waitn(1);
      if (d_wrap[1]) wraps++;
    end
    n_checks++;
    if (wraps !== 0) begin n_fail++; $display("FAIL wrap_quiet: got %0d pulses expected 0", wraps); end
  endtask

  task automatic test_lap();
    logic [18:0] e;
    mode = 1'b0;
    pulse_clear();
    press_ss();
    waitn(20);
    press_lap();
    e = {to_disp(5), 4'b1100};
    n_checks++;
    if (obs_vec(0) !== e) begin n_fail++; $display("FAIL lap_set: got %h expected %h", obs_vec(0), e); end
    waitn(11);
    n_checks++;
    if (obs_vec(0) !== e) begin n_fail++; $display("FAIL lap_frozen: got %h expected %h", obs_vec(0), e); end
    press_lap();
    e = {to_disp(8), 4'b1000};
    n_checks++;
    if (obs_vec(0) !== e) begin n_fail++; $display("FAIL lap_release: got %h expected %h", obs_vec(0), e); end
  endtask

  task automatic test_down();
    logic [18:0] e;
    mode = 1'b1;
    preset_mt = 4'd0; preset_mu = 4'd0; preset_st = 3'd0; preset_su = 4'd3;
    pulse_clear();
    press_ss();
    waitn(12);
    e = {to_disp(0), 4'b0010};
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs_vec(k) !== e) begin n_fail++; $display("FAIL down_done dut%0d: got %h expected %h", k, obs_vec(k), e); end
    end
    press_ss();
    press_lap();
    waitn(8);
    n_checks++;
    if (obs_vec(0) !== e) begin n_fail++; $display("FAIL done_sticky: got %h expected %h", obs_vec(0), e); end
    pulse_clear();
    e = {to_disp(3), 4'b0000};
    n_checks++;
    if (obs_vec(0) !== e) begin n_fail++; $display("FAIL done_clear: got %h expected %h", obs_vec(0), e); end
    // Down mode starting at 00:00 completes immediately.
    preset_su = 4'd0;
    pulse_clear();
    waitn(1);
    press_ss();
    e = {to_disp(0), 4'b0010};
    n_checks++;
    if (obs_vec(0) !== e) begin n_fail++; $display("FAIL down_zero_start: got %h expected %h", obs_vec(0), e); end
  endtask

  task automatic test_clamp();
    logic [18:0] e;
    mode = 1'b1;
    preset_mt = 4'd7; preset_mu = 4'd12; preset_st = 3'd7; preset_su = 4'd15;
    pulse_clear();
    e = {to_disp(59 * 60 + 59), 4'b0000};
    n_checks++;
    if (obs_vec(0) !== e) begin n_fail++; $display("FAIL clamp_59: got %h expected %h", obs_vec(0), e); end
    e = {to_disp(119), 4'b0000};
    n_checks++;
    if (obs_vec(1) !== e) begin n_fail++; $display("FAIL clamp_max1: got %h expected %h", obs_vec(1), e); end
  endtask

  task automatic test_async_reset();
    mode = 1'b0;
    pulse_clear();
    press_ss();
    waitn(10);
    press_lap();
    waitn(5);
    n_checks++;
    if (d_lap[0] !== 1'b1) begin n_fail++; $display("FAIL areset_setup: got %b expected 1", d_lap[0]); end
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs_vec(k) !== 19'd0) begin
        n_fail++; $display("FAIL areset_immediate dut%0d: got %h expected %h", k, obs_vec(k), 19'd0);
      end
    end
    @(negedge clk) reset = 1'b1;
    waitn(3);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs_vec(k) !== 19'd0) begin
        n_fail++; $display("FAIL areset_idle dut%0d: got %h expected %h", k, obs_vec(k), 19'd0);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          n_fail++; $display("FAIL random cyc%0d dut%0d: got %h expected %h", i, k, obs_vec(k), exp_vec(k));
        end
      end
      start_stop = ($urandom_range(0, 9) == 0);
      lap        = ($urandom_range(0, 7) == 0);
      clear      = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 29) == 0) mode = $urandom_range(0, 1);
      if ($urandom_range(0, 49) == 0) begin
        preset_mt = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
        preset_mu = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
        preset_st = 3'($urandom_range(0, 7));
        preset_su = 4'($urandom_range(0, 15));
      end
    end
    @(negedge clk);
    start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
  endtask

  initial begin
    test_reset();
    test_run_pause();
    test_wrap();
    test_lap();
    test_down();
    test_clamp();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
